gbdt_ram_scan_ctrl: RTL
=======================

// Module: gbdt_ram_scan_ctrl
// PURPOSE
// Read-phase sequencer for the 32-RAM GBDT model store (8 groups x 4 RAMs per group).
// Starts on gbdt_start and walks every active round (0..3), reading word addresses 0..num_words-1 in each.
// Drives the round/address/cs/oe/we controls of the register-file RAM array and tags each returned word for the core.
// Skips rounds with no used class, honours core back-pressure and reports busy/done.
// PARAMETERS
// ADDR_W      8  RAM word-address width (matches `RAM_ADDR_WIDTH)
// NUM_GROUPS  8  groups per round; one RAM per group is read in parallel
// NUM_ROUNDS  4  RAMs per group; round index selects which one
// PORTS
// gbdt_clk      in   1             clock
// gbdt_rst_n    in   1             reset; asynchronous, active-low
// gbdt_start    in   1             1-cycle start pulse from APB start register
// used_classes  in   32            class enable; bit g+8*r = RAM of group g, round r
// num_words     in   ADDR_W+1      words per RAM to scan, 0..2^ADDR_W; sampled at start
// core_ready    in   1             core can accept a word next cycle
// round         out  2             active round to RAM array
// ram_addr      out  ADDR_W        read address, replicated to all 8 groups by the integrator
// cs            out  1             RAM chip select (read issue)
// oe            out  1             RAM output enable, equal to cs
// we            out  1             RAM write enable; constant 0 from this block
// group_mask    out  NUM_GROUPS    used_classes slice of the round in rd_round; valid with rd_valid
// rd_valid      out  1             RAM data bus holds the word for rd_round/rd_addr
// rd_round      out  2             round tag of the returned word
// rd_addr       out  ADDR_W        address tag of the returned word
// rd_last       out  1             final word of the final active round
// busy          out  1             scan in progress; APB RAM writes are blocked by the integrator while high
// done          out  1             1-cycle pulse when the scan completes
// BEHAVIOUR
// - Reset: all outputs are 0 (round=0, ram_addr=0, cs=oe=we=0, rd_*=0, busy=0, done=0). State goes to IDLE.
//   Reset asserted mid-scan aborts at once; no done pulse is produced.
// - FSM states: IDLE, SCAN, DRAIN, FIN.
//   - IDLE: gbdt_start=1 captures num_words and used_classes and sets busy=1 next cycle.
//     - Next state is SCAN, starting at the first round r with |used_classes[8r+7:8r] != 0.
//     - If no round is active, or num_words==0, next state is FIN.
//   - SCAN: in each cycle with core_ready=1, issue a read: cs=oe=1, round=r, ram_addr=a (all registered).
//     - After each issue, a increments. At a==num_words-1, a returns to 0 and r advances to the next active round.
//     - If no active round remains, next state is DRAIN.
//     - When core_ready=0, cs=oe=0 and a/r hold. There are no idle holes otherwise.
//   - DRAIN: wait for the final rd_valid, then go to FIN.
//   - FIN: done=1 for one cycle, busy=0, then IDLE.
// - Read latency: one cycle. rd_valid, rd_round, rd_addr and group_mask are cs, round and ram_addr delayed by one cycle.
//   group_mask = captured used_classes[8*rd_round +: 8].
// - Back-pressure: the core must accept any rd_valid that arrives the cycle after it drops core_ready.
//   At most one word is in flight.
// - Start latency: start sampled in cycle T -> busy=1 at T+1, first cs at T+1 if core_ready=1 at T.
// - Scan length: num_words is ADDR_W+1 bits wide, so 2^ADDR_W scans the full RAM.
//   The address counter never wraps past num_words-1.
// - gbdt_start while busy is ignored. used_classes/num_words changes mid-scan are ignored (captured copies are used).
// - done and gbdt_start in the same cycle: start is accepted (FIN -> SCAN directly), done still pulses.
// - Skipped rounds take zero cycles.
// TESTING
// - All 32 used, num_words=4, core_ready=1: 16 consecutive cs cycles (r0a0..r3a3).
//   rd_last with rd_round=3/rd_addr=3; done 2 cycles after the last cs.
// - used_classes=32'h00FF00FF, num_words=2: rounds 0,2 only; 4 reads; group_mask=8'hFF; no round 1/3 issue.
// - used_classes=0 or num_words=0: start -> done pulse at T+1 with busy for 1 cycle, and cs never asserted.
// - core_ready toggled 1,0,0,1 during SCAN: no issue while 0; the in-flight word is still returned; address sequence has no gaps or duplicates.
// - Second gbdt_start mid-scan ignored; async reset at word 5 of 16: outputs 0 immediately, no done; a new start rescans from r0a0.
// - num_words=2^ADDR_W: ram_addr reaches all-ones, then the round advances; no wrap to 0 in the same round.

Source files
------------

// File: rtl/gbdt_ram_scan_ctrl.sv
// Read-phase sequencer for the GBDT model RAM array: walks every active round,
// issues one read per cycle under core back-pressure and tags each returned word.
module gbdt_ram_scan_ctrl #(
    parameter  int ADDR_W     = 8,
    parameter  int NUM_GROUPS = 8,
    parameter  int NUM_ROUNDS = 4,
    localparam int RW         = $clog2(NUM_ROUNDS),
    localparam int UW         = NUM_GROUPS * NUM_ROUNDS
) (
    input  logic                  gbdt_clk,
    input  logic                  gbdt_rst_n,
    input  logic                  gbdt_start,
    input  logic [UW-1:0]         used_classes,
    input  logic [ADDR_W:0]       num_words,
    input  logic                  core_ready,
    output logic [RW-1:0]         round,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic                  cs,
    output logic                  oe,
    output logic                  we,
    output logic [NUM_GROUPS-1:0] group_mask,
    output logic                  rd_valid,
    output logic [RW-1:0]         rd_round,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_last,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, FIN} state_t;

    localparam logic [RW:0]       ONE_R = 1;
    localparam logic [ADDR_W:0]   ONE_W = 1;
    localparam logic [ADDR_W-1:0] ONE_A = 1;

    state_t                  st, st_n;
    logic [RW-1:0]           cur_r, cur_r_n, iss_r;
    logic [ADDR_W-1:0]       cur_a, cur_a_n, iss_a;
    logic [UW-1:0]           cap_used, cap_used_n, use_used;
    logic [ADDR_W:0]         cap_nw, cap_nw_n, use_nw;
    logic                    issue, iss_last, last_iss;
    logic [RW:0]             first, nxt;
    logic [NUM_GROUPS-1:0]   gm_n;

    // Lowest round index >= from whose class slice is non-empty; MSB flags "found".
    function automatic logic [RW:0] find_active(input logic [UW-1:0] used, input logic [RW:0] from);
        logic [RW:0] res;
        res = '0;
        for (int r = NUM_ROUNDS - 1; r >= 0; r--) begin
            if (r >= int'(from) && |used[r*NUM_GROUPS +: NUM_GROUPS])
                res = {1'b1, RW'(r)};
        end
        return res;
    endfunction

    always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
        if (!gbdt_rst_n) st <= IDLE;
        else             st <= st_n;
    end

    // A start accepted in IDLE/FIN issues its first read in the same decision cycle.
    always_comb begin
        st_n       = st;
        cur_r_n    = cur_r;
        cur_a_n    = cur_a;
        cap_used_n = cap_used;
        cap_nw_n   = cap_nw;
        use_used   = cap_used;
        use_nw     = cap_nw;
        iss_r      = cur_r;
        iss_a      = cur_a;
        issue      = 1'b0;
        iss_last   = 1'b0;
        first      = find_active(used_classes, '0);
        case (st)
            IDLE, FIN: begin
                st_n = IDLE;
                if (gbdt_start) begin
                    cap_used_n = used_classes;
                    cap_nw_n   = num_words;
                    if (!first[RW] || num_words == '0) begin
                        st_n = FIN;
                    end else begin
                        st_n     = SCAN;
                        use_used = used_classes;
                        use_nw   = num_words;
                        iss_r    = first[RW-1:0];
                        iss_a    = '0;
                        cur_r_n  = first[RW-1:0];
                        cur_a_n  = '0;
                        issue    = core_ready;
                    end
                end
            end
            SCAN:    issue = core_ready;
            DRAIN:   if (rd_last) st_n = FIN;
            default: st_n = IDLE;
        endcase
        nxt = find_active(use_used, {1'b0, iss_r} + ONE_R);
        if (issue) begin
            if ({1'b0, iss_a} == use_nw - ONE_W) begin
                cur_a_n = '0;
                if (nxt[RW]) begin
                    cur_r_n = nxt[RW-1:0];
                end else begin
                    iss_last = 1'b1;
                    st_n     = DRAIN;
                end
            end else begin
                cur_a_n = iss_a + ONE_A;
            end
        end
    end

    always_comb begin
        gm_n = '0;
        for (int r = 0; r < NUM_ROUNDS; r++) begin
            if (round == RW'(r)) gm_n = cap_used[r*NUM_GROUPS +: NUM_GROUPS];
        end
    end

    always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
        if (!gbdt_rst_n) begin
            cur_r      <= '0;
            cur_a      <= '0;
            cap_used   <= '0;
            cap_nw     <= '0;
            round      <= '0;
            ram_addr   <= '0;
            cs         <= 1'b0;
            last_iss   <= 1'b0;
            rd_valid   <= 1'b0;
            rd_round   <= '0;
            rd_addr    <= '0;
            rd_last    <= 1'b0;
            group_mask <= '0;
        end else begin
            cur_r    <= cur_r_n;
            cur_a    <= cur_a_n;
            cap_used <= cap_used_n;
            cap_nw   <= cap_nw_n;
            cs       <= issue;
            last_iss <= issue & iss_last;
            if (issue) begin
                round    <= iss_r;
                ram_addr <= iss_a;
            end
            // One-cycle RAM read latency: tags follow the issued controls.
            rd_valid   <= cs;
            rd_round   <= round;
            rd_addr    <= ram_addr;
            rd_last    <= cs & last_iss;
            group_mask <= gm_n;
        end
    end

    assign oe   = cs;
    assign we   = 1'b0;
    assign busy = (st != IDLE);
    assign done = (st == FIN);

endmodule
